elevator_motion_ctrl: RTL and testbench



---
 rtl/elevator_motion_ctrl_if.sv | 25 ++
 rtl/elevator_motion_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_elevator_motion_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/elevator_motion_ctrl_if.sv
// Floor-call / step-tick inputs and stepper-driver outputs of the elevator trip controller.
interface elevator_motion_ctrl_if #(
   parameter int unsigned NUM_FLOORS = 4
);
   localparam int unsigned FW = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;

   logic [NUM_FLOORS-1:0] call;
   logic                  step_pulse;
   logic                  start;
   logic                  dir;
   logic [1:0]            speed;
   logic [FW-1:0]         floor;
   logic                  door_open;
   logic                  moving;

   modport master (
      input  call, step_pulse,
      output start, dir, speed, floor, door_open, moving
   );

   modport slave (
      output call, step_pulse,
      input  start, dir, speed, floor, door_open, moving
   );
endinterface

// File: rtl/elevator_motion_ctrl.sv
// Elevator trip controller: latches floor calls, tracks car position in motor steps,
// drives stepper start/dir/speed with a step-counted ramp and times the door.
module elevator_motion_ctrl #(
   parameter int unsigned NUM_FLOORS      = 4,
   parameter int unsigned STEPS_PER_FLOOR = 200,
   parameter int unsigned RAMP_STEPS      = 20,
   parameter int unsigned DOOR_CYCLES     = 50000000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   elevator_motion_ctrl_if.master bus
);
   localparam int unsigned FW      = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;
   localparam int unsigned POS_MAX = (NUM_FLOORS - 1) * STEPS_PER_FLOOR;
   localparam int unsigned PW      = (POS_MAX > 0) ? $clog2(POS_MAX + 1) : 1;
   localparam int unsigned TW      = (DOOR_CYCLES > 0) ? $clog2(DOOR_CYCLES + 1) : 1;

   localparam logic [PW-1:0] POS_LIM = PW'(POS_MAX);
   localparam logic [PW-1:0] SPF     = PW'(STEPS_PER_FLOOR);
   localparam logic [PW-1:0] RAMP1   = PW'(RAMP_STEPS);
   localparam logic [PW-1:0] RAMP2   = PW'(2 * RAMP_STEPS);
   localparam logic [TW-1:0] TLOAD   = TW'(DOOR_CYCLES);

   typedef enum logic [1:0] {ST_IDLE, ST_DOOR, ST_MOVE} state_t;

   state_t                r_state,  w_state_nxt;
   logic [PW-1:0]         r_pos,    w_pos_nxt;
   logic [PW-1:0]         r_done,   w_done_nxt;
   logic [TW-1:0]         r_timer,  w_timer_nxt;
   logic [NUM_FLOORS-1:0] r_req,    w_req_nxt;
   logic [FW-1:0]         r_target, w_target_nxt;
   logic [FW-1:0]         r_floor,  w_floor_nxt;
   logic                  r_dir,    w_dir_nxt;
   logic                  r_start,  w_start_nxt;
   logic [1:0]            r_speed,  w_speed_nxt;
   logic                  r_door,   w_door_nxt;
   logic                  r_moving, w_moving_nxt;

   logic [NUM_FLOORS-1:0] w_clr;
   logic                  w_up_found, w_dn_found;
   logic [FW-1:0]         w_up_tgt,   w_dn_tgt;
   logic [PW-1:0]         w_floor_pos, w_tgt_pos, w_left;
   logic                  w_at_floor;

   assign w_floor_pos = PW'(r_floor) * SPF;
   assign w_tgt_pos   = PW'(r_target) * SPF;
   assign w_at_floor  = (r_pos == w_floor_pos);

   // Nearest pending request above (lowest index) and below (highest index) the car.
   always_comb begin : p_search
      w_up_found = 1'b0;
      w_up_tgt   = '0;
      w_dn_found = 1'b0;
      w_dn_tgt   = '0;
      for (int i = int'(NUM_FLOORS) - 1; i >= 0; i--) begin
         if (r_req[i] && (FW'(i) > r_floor)) begin
            w_up_found = 1'b1;
            w_up_tgt   = FW'(i);
         end
      end
      for (int i = 0; i < int'(NUM_FLOORS); i++) begin
         if (r_req[i] && (FW'(i) < r_floor)) begin
            w_dn_found = 1'b1;
            w_dn_tgt   = FW'(i);
         end
      end
   end

   always_comb begin : p_next
      w_state_nxt  = r_state;
      w_pos_nxt    = r_pos;
      w_done_nxt   = r_done;
      w_timer_nxt  = r_timer;
      w_target_nxt = r_target;
      w_dir_nxt    = r_dir;
      w_start_nxt  = 1'b0;
      w_speed_nxt  = 2'b00;
      w_door_nxt   = 1'b0;
      w_moving_nxt = 1'b0;
      w_clr        = '0;
      w_left       = '0;

      case (r_state)
         ST_IDLE: begin
            if (r_req[r_floor] && w_at_floor) begin
               w_state_nxt    = ST_DOOR;
               w_clr[r_floor] = 1'b1;
               w_timer_nxt    = TLOAD;
               w_door_nxt     = 1'b1;
            end else if (w_up_found || w_dn_found) begin
               w_state_nxt  = ST_MOVE;
               w_start_nxt  = 1'b1;
               w_moving_nxt = 1'b1;
               w_speed_nxt  = 2'b01;
               w_done_nxt   = '0;
               // Keep heading if something lies ahead, otherwise reverse.
               if ((r_dir && w_up_found) || !w_dn_found) begin
                  w_target_nxt = w_up_tgt;
                  w_dir_nxt    = 1'b1;
               end else begin
                  w_target_nxt = w_dn_tgt;
                  w_dir_nxt    = 1'b0;
               end
            end
         end

         ST_MOVE: begin
            w_start_nxt  = 1'b1;
            w_moving_nxt = 1'b1;
            w_speed_nxt  = r_speed;
            if (bus.step_pulse && (r_dir ? (r_pos != POS_LIM) : (r_pos != '0))) begin
               w_pos_nxt = r_dir ? (r_pos + 1'b1) : (r_pos - 1'b1);
               if (r_done != '1) begin
                  w_done_nxt = r_done + 1'b1;
               end
               w_left = (w_tgt_pos >= w_pos_nxt) ? (w_tgt_pos - w_pos_nxt)
                                                 : (w_pos_nxt - w_tgt_pos);
               if (w_left == '0) begin
                  w_state_nxt     = ST_DOOR;
                  w_start_nxt     = 1'b0;
                  w_moving_nxt    = 1'b0;
                  w_speed_nxt     = 2'b00;
                  w_door_nxt      = 1'b1;
                  w_timer_nxt     = TLOAD;
                  w_clr[r_target] = 1'b1;
               end else if ((w_done_nxt < RAMP1) || (w_left <= RAMP1)) begin
                  w_speed_nxt = 2'b01;
               end else if ((w_done_nxt < RAMP2) || (w_left <= RAMP2)) begin
                  w_speed_nxt = 2'b10;
               end else begin
                  w_speed_nxt = 2'b11;
               end
            end
         end

         ST_DOOR: begin
            w_door_nxt     = 1'b1;
            w_clr[r_floor] = 1'b1;
            if (bus.call[r_floor]) begin
               w_timer_nxt = TLOAD;
            end else if (r_timer <= TW'(1)) begin
               w_timer_nxt = '0;
               w_state_nxt = ST_IDLE;
               w_door_nxt  = 1'b0;
            end else begin
               w_timer_nxt = r_timer - 1'b1;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // Clear beats a fresh call only while the door is open at that floor.
      w_req_nxt   = (r_state == ST_DOOR) ? ((r_req | bus.call) & ~w_clr)
                                         : ((r_req & ~w_clr) | bus.call);
      w_floor_nxt = FW'(w_pos_nxt / SPF);
   end

   always_ff @(posedge clk or negedge rst_n) begin : p_regs
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_pos    <= '0;
         r_done   <= '0;
         r_timer  <= '0;
         r_req    <= '0;
         r_target <= '0;
         r_floor  <= '0;
         r_dir    <= 1'b1;
         r_start  <= 1'b0;
         r_speed  <= 2'b00;
         r_door   <= 1'b0;
         r_moving <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_pos    <= w_pos_nxt;
         r_done   <= w_done_nxt;
         r_timer  <= w_timer_nxt;
         r_req    <= w_req_nxt;
         r_target <= w_target_nxt;
         r_floor  <= w_floor_nxt;
         r_dir    <= w_dir_nxt;
         r_start  <= w_start_nxt;
         r_speed  <= w_speed_nxt;
         r_door   <= w_door_nxt;
         r_moving <= w_moving_nxt;
      end
   end

   assign bus.start     = r_start;
   assign bus.dir       = r_dir;
   assign bus.speed     = r_speed;
   assign bus.floor     = r_floor;
   assign bus.door_open = r_door;
   assign bus.moving    = r_moving;
endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// Directed-vector bench for elevator_motion_ctrl, run with a shortened door time.
module tb_elevator_motion_ctrl;
   localparam int unsigned NF   = 4;
   localparam int unsigned SPF  = 200;
   localparam int unsigned RAMP = 20;
   localparam int unsigned DC   = 30;

   // call pulsed for one cycle, then idle cycles, then step pulses, then compare outputs
   typedef struct {
      logic [3:0]  call;
      int unsigned idle;
      int unsigned steps;
      logic [7:0]  want;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   elevator_motion_ctrl_if #(.NUM_FLOORS(NF)) bus ();

   elevator_motion_ctrl #(
      .NUM_FLOORS      (NF),
      .STEPS_PER_FLOOR (SPF),
      .RAMP_STEPS      (RAMP),
      .DOOR_CYCLES     (DC)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // {start, dir, speed[1:0], floor[1:0], door_open, moving}
   function automatic logic [7:0] o(input logic st, input logic dr, input logic [1:0] sp,
                                    input logic [1:0] fl, input logic dor, input logic mv);
      return {st, dr, sp, fl, dor, mv};
   endfunction

   function automatic logic [7:0] outs();
      return {bus.start, bus.dir, bus.speed, bus.floor, bus.door_open, bus.moving};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      bus.step_pulse = 1'b0;
      tick();
      bus.step_pulse = 1'b1;
      tick();
      bus.step_pulse = 1'b0;
   endtask

   task automatic apply_vec(input vec_t v, input string name);
      if (v.call != 4'b0000) begin
         bus.call = v.call;
         tick();
         bus.call = 4'b0000;
      end
      repeat (v.idle) tick();
      repeat (v.steps) step();
      chk(name, 32'(outs()), 32'(v.want));
   endtask

   // Counts cycles until door_open falls, bounded; optionally toggles step_pulse meanwhile.
   task automatic wait_door(input bit pulse, output int n);
      n = 0;
      while (bus.door_open && n < int'(DC) + 10) begin
         bus.step_pulse = pulse & n[0];
         tick();
         n++;
      end
      bus.step_pulse = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t       vecs [0:12];
      int         n;
      int         mism;
      logic [1:0] exp_sp;
      logic       moved;

      // Trip 0 -> 2 (target pos 400), checked at the ramp band edges.
      vecs[0]  = '{4'b0100, 1, 0,   o(1, 1, 2'b01, 2'd0, 0, 1)};
      vecs[1]  = '{4'b0000, 0, 19,  o(1, 1, 2'b01, 2'd0, 0, 1)};
      vecs[2]  = '{4'b0000, 0, 1,   o(1, 1, 2'b10, 2'd0, 0, 1)};
      vecs[3]  = '{4'b0000, 0, 19,  o(1, 1, 2'b10, 2'd0, 0, 1)};
      vecs[4]  = '{4'b0000, 0, 1,   o(1, 1, 2'b11, 2'd0, 0, 1)};
      vecs[5]  = '{4'b0000, 0, 159, o(1, 1, 2'b11, 2'd0, 0, 1)};
      vecs[6]  = '{4'b0000, 0, 1,   o(1, 1, 2'b11, 2'd1, 0, 1)};
      vecs[7]  = '{4'b0000, 0, 159, o(1, 1, 2'b11, 2'd1, 0, 1)};
      vecs[8]  = '{4'b0000, 0, 1,   o(1, 1, 2'b10, 2'd1, 0, 1)};
      vecs[9]  = '{4'b0000, 0, 19,  o(1, 1, 2'b10, 2'd1, 0, 1)};
      vecs[10] = '{4'b0000, 0, 1,   o(1, 1, 2'b01, 2'd1, 0, 1)};
      vecs[11] = '{4'b0000, 0, 19,  o(1, 1, 2'b01, 2'd1, 0, 1)};
      vecs[12] = '{4'b0000, 0, 1,   o(0, 1, 2'b00, 2'd2, 1, 0)};

      rst_n          = 1'b0;
      bus.call       = 4'b0000;
      bus.step_pulse = 1'b0;
      repeat (3) tick();
      chk("reset_outs", 32'(outs()), 32'(o(0, 1, 2'b00, 2'd0, 0, 0)));
      rst_n = 1'b1;
      tick();
      chk("idle_after_release", 32'(outs()), 32'(o(0, 1, 2'b00, 2'd0, 0, 0)));

      for (int i = 0; i < 13; i++) begin
         apply_vec(vecs[i], $sformatf("trip02_vec%0d", i));
      end

      wait_door(1'b1, n);
      chk("door_len_f2", 32'(n), 32'(DC));
      chk("idle_f2", 32'(outs()), 32'(o(0, 1, 2'b00, 2'd2, 0, 0)));
      repeat (5) step();
      chk("idle_pulses_ignored", 32'(outs()), 32'(o(0, 1, 2'b00, 2'd2, 0, 0)));

      // Calls at 0 and 3 together from floor 2 heading up: 3 first, then 0.
      apply_vec('{4'b1001, 1, 0,   o(1, 1, 2'b01, 2'd2, 0, 1)}, "dep_f2_up_first");
      apply_vec('{4'b0000, 0, 199, o(1, 1, 2'b01, 2'd2, 0, 1)}, "f3_pre_arrive");
      apply_vec('{4'b0000, 0, 1,   o(0, 1, 2'b00, 2'd3, 1, 0)}, "arrive_f3");
      wait_door(1'b0, n);
      chk("door_len_f3", 32'(n), 32'(DC));
      tick();
      chk("dep_f3_down", 32'(outs()), 32'(o(1, 0, 2'b01, 2'd3, 0, 1)));
      apply_vec('{4'b0000, 0, 300, o(1, 0, 2'b11, 2'd1, 0, 1)}, "f0_mid");
      apply_vec('{4'b0000, 0, 300, o(0, 0, 2'b00, 2'd0, 1, 0)}, "arrive_f0");
      wait_door(1'b0, n);
      chk("door_len_f0", 32'(n), 32'(DC));

      // Single-floor trip 0 -> 1: 01 x20, 10 x20, 11 x120, 10 x20, 01 x20.
      apply_vec('{4'b0010, 1, 0, o(1, 1, 2'b01, 2'd0, 0, 1)}, "dep_f0_up");
      mism = 0;
      for (int k = 0; k < 200; k++) begin
         if (k > 0) step();
         if (k < 20)       exp_sp = 2'b01;
         else if (k < 40)  exp_sp = 2'b10;
         else if (k < 160) exp_sp = 2'b11;
         else if (k < 180) exp_sp = 2'b10;
         else              exp_sp = 2'b01;
         if (bus.speed !== exp_sp) mism++;
      end
      chk("trip01_profile_mismatches", 32'(mism), 32'd0);
      apply_vec('{4'b0000, 0, 1, o(0, 1, 2'b00, 2'd1, 1, 0)}, "arrive_f1");

      // Call at the current floor while the door is open restarts the door time.
      repeat (10) tick();
      bus.call = 4'b0010;
      tick();
      bus.call = 4'b0000;
      moved = 1'b0;
      n = 0;
      while (bus.door_open && n < int'(DC) + 10) begin
         if (bus.start || bus.moving) moved = 1'b1;
         tick();
         n++;
      end
      chk("door_reload_len", 32'(n), 32'(DC));
      chk("door_reload_no_move", 32'(moved), 32'd0);
      repeat (3) tick();
      chk("no_reopen_f1", 32'(outs()), 32'(o(0, 1, 2'b00, 2'd1, 0, 0)));

      // Reset mid-trip at pos 150 with another call pending.
      apply_vec('{4'b0001, 1, 0,  o(1, 0, 2'b01, 2'd1, 0, 1)}, "dep_f1_down");
      apply_vec('{4'b0000, 0, 50, o(1, 0, 2'b11, 2'd0, 0, 1)}, "pos150");
      bus.call = 4'b1000;
      tick();
      bus.call = 4'b0000;
      rst_n = 1'b0;
      #2;
      chk("reset_async", 32'(outs()), 32'(o(0, 1, 2'b00, 2'd0, 0, 0)));
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      chk("reset_req_cleared", 32'(outs()), 32'(o(0, 1, 2'b00, 2'd0, 0, 0)));
      apply_vec('{4'b0001, 1, 0, o(0, 1, 2'b00, 2'd0, 1, 0)}, "post_reset_door_f0");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
